// File: rtl/fetch_queue.sv
// fetch_queue: sequential instruction fetch with in-order response FIFO and redirect flush
// Ports: clk, rst (async active-high); imem_req_valid/ready/addr request channel;
// imem_rsp_valid/instr in-order responses; instr_valid/ready, instr, instr_pc to the core;
// redirect/redirect_pc taken-branch target. Defining FETCH_QUEUE_STATS_EN adds the
// stall_cycles and dropped_rsps saturating counters.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
`ifdef FETCH_QUEUE_STATS_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] dropped_rsps
`endif
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  logic [31:0] fetch_pc, rsp_pc, target;
  logic [CW-1:0] outstanding, drop, count, out_next;
  logic [CW:0] inflight;
  logic [PW-1:0] head, tail;
  logic [31:0] mem_instr [DEPTH];
  logic [31:0] mem_pc [DEPTH];
  logic req_fire, pop, push, discard;
  // Buffered plus in-flight entries bound the FIFO, so a response can never overflow it.
  assign inflight = {1'b0, count} + {1'b0, outstanding};
  assign imem_req_valid = !redirect && (inflight < (CW+1)'(DEPTH));
  assign imem_req_addr = fetch_pc;
  assign req_fire = imem_req_valid && imem_req_ready;
  assign instr_valid = count != '0;
  assign instr = instr_valid ? mem_instr[head] : '0;
  assign instr_pc = instr_valid ? mem_pc[head] : '0;
  assign pop = instr_valid && instr_ready;
  // A response landing in the redirect cycle belongs to the old path and is thrown away.
  assign discard = imem_rsp_valid && (redirect || drop != '0);
  assign push = imem_rsp_valid && !discard;
  assign out_next = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
  assign target = redirect_pc & ~32'h3;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      rsp_pc <= RESET_PC;
      outstanding <= '0;
      drop <= '0;
      count <= '0;
      head <= '0;
      tail <= '0;
    end else begin
      outstanding <= out_next;
      if (redirect) begin
        fetch_pc <= target;
        rsp_pc <= target;
        drop <= out_next;
        count <= '0;
        head <= '0;
        tail <= '0;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (push) rsp_pc <= rsp_pc + 32'd4;
        if (push) tail <= tail + 1'b1;
        if (pop) head <= head + 1'b1;
        if (discard) drop <= drop - 1'b1;
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[tail] <= imem_rsp_instr;
      mem_pc[tail] <= rsp_pc;
    end
  end
`ifdef FETCH_QUEUE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      dropped_rsps <= '0;
    end else begin
      if (instr_ready && !instr_valid && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
      if (discard && dropped_rsps != '1) dropped_rsps <= dropped_rsps + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized bench for fetch_queue with a queue-based reference model
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  logic clk = 1'b0, rst = 1'b1;
  logic imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_instr = '0;
  logic instr_valid, instr_ready = 1'b0;
  logic [31:0] instr, instr_pc;
  logic redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
`ifdef FETCH_QUEUE_STATS_EN
  logic [31:0] stall_cycles, dropped_rsps;
  logic [31:0] m_stall, m_dropped;
`endif
  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_instr(imem_rsp_instr),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .redirect(redirect), .redirect_pc(redirect_pc)
`ifdef FETCH_QUEUE_STATS_EN
    , .stall_cycles(stall_cycles), .dropped_rsps(dropped_rsps)
`endif
  );
  always #5 clk = ~clk;
  typedef struct { logic [31:0] addr; int due; } req_t;
  typedef struct { logic [31:0] i; logic [31:0] pc; } ent_t;
  req_t mq[$];
  ent_t q[$];
  int cyc = 0, lat = 1, last_due = 0;
  int n_checks = 0, n_pass = 0;
  logic [31:0] m_fetch, m_rsp;
  int m_out, m_drop;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction
  always @(posedge clk) cyc <= cyc + 1;
  // Instruction memory: in-order responses, at least lat cycles after acceptance.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      mq.delete();
      imem_rsp_valid = 1'b0;
    end else if (mq.size() != 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_instr = mem_word(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_instr = $urandom;
    end
  end
  always @(negedge clk) begin
    int d;
    if (rst) begin
      mq.delete();
      last_due = 0;
    end else if (imem_req_valid && imem_req_ready) begin
      d = cyc + lat;
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      mq.push_back('{addr: imem_req_addr, due: d});
    end
  end
  // Reference model: delivered stream as a queue of {word, pc}, updated once per cycle.
  always @(negedge clk) begin
    logic ev, erv;
    logic [31:0] ei, ep;
    if (rst) begin
      q.delete();
      m_fetch = RESET_PC;
      m_rsp = RESET_PC;
      m_out = 0;
      m_drop = 0;
      n_checks++;
      if ({instr_valid, instr, instr_pc, imem_req_addr} !== {1'b0, 32'h0, 32'h0, RESET_PC})
        $display("FAIL sb_reset: got v=%b i=%h pc=%h addr=%h expected 0/0/0/%h", instr_valid, instr, instr_pc, imem_req_addr, RESET_PC);
      else n_pass++;
`ifdef FETCH_QUEUE_STATS_EN
      m_stall = 0;
      m_dropped = 0;
`endif
    end else begin
      ev = q.size() != 0;
      ei = ev ? q[0].i : 32'h0;
      ep = ev ? q[0].pc : 32'h0;
      erv = !redirect && (q.size() + m_out < DEPTH);
      n_checks++;
      if (imem_req_valid !== erv || imem_req_addr !== m_fetch)
        $display("FAIL sb_req cyc=%0d: got v=%b addr=%h expected v=%b addr=%h", cyc, imem_req_valid, imem_req_addr, erv, m_fetch);
      else n_pass++;
      n_checks++;
      if (instr_valid !== ev || instr !== ei || instr_pc !== ep)
        $display("FAIL sb_out cyc=%0d: got v=%b i=%h pc=%h expected v=%b i=%h pc=%h", cyc, instr_valid, instr, instr_pc, ev, ei, ep);
      else n_pass++;
`ifdef FETCH_QUEUE_STATS_EN
      n_checks++;
      if (stall_cycles !== m_stall || dropped_rsps !== m_dropped)
        $display("FAIL sb_stats cyc=%0d: got %0d/%0d expected %0d/%0d", cyc, stall_cycles, dropped_rsps, m_stall, m_dropped);
      else n_pass++;
      if (instr_ready && !ev) m_stall++;
      if (imem_rsp_valid && (redirect || m_drop > 0)) m_dropped++;
`endif
      if (ev && instr_ready) void'(q.pop_front());
      if (erv && imem_req_ready) begin
        m_out++;
        m_fetch += 4;
      end
      if (imem_rsp_valid) begin
        m_out--;
        if (redirect) ;
        else if (m_drop > 0) m_drop--;
        else begin
          q.push_back('{i: mem_word(m_rsp), pc: m_rsp});
          m_rsp += 4;
        end
      end
      if (redirect) begin
        q.delete();
        m_fetch = {redirect_pc[31:2], 2'b00};
        m_rsp = m_fetch;
        m_drop = m_out;
      end
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    tick();
    rst = 1'b1;
    redirect = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask
  task automatic test_reset;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({instr_valid, instr, instr_pc, imem_req_addr} !== {1'b0, 32'h0, 32'h0, RESET_PC})
      $display("FAIL reset_state: got v=%b i=%h pc=%h addr=%h", instr_valid, instr, instr_pc, imem_req_addr);
    else n_pass++;
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (imem_req_valid !== 1'b1) $display("FAIL reset_release_req: got %b expected 1", imem_req_valid);
    else n_pass++;
  endtask
  task automatic test_stream;
    do_reset();
    lat = 1;
    imem_req_ready = 1'b1;
    instr_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_checks++;
      if (i < 2 ? instr_valid !== 1'b0 : (instr_valid !== 1'b1 || instr_pc !== 32'(4 * (i - 2))))
        $display("FAIL stream[%0d]: got v=%b pc=%h expected pc=%h", i, instr_valid, instr_pc, 4 * (i - 2));
      else n_pass++;
    end
  endtask
  task automatic test_backpressure;
    int hs;
    hs = 0;
    do_reset();
    lat = 1;
    imem_req_ready = 1'b1;
    instr_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) hs++;
    end
    n_checks++;
    if (hs !== 4 || imem_req_valid !== 1'b0) $display("FAIL bp_fill: got %0d reqs valid=%b expected 4 valid=0", hs, imem_req_valid);
    else n_pass++;
    tick();
    instr_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      n_checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * j)) $display("FAIL bp_drain[%0d]: got pc=%h expected %h", j, instr_pc, 4 * j);
      else n_pass++;
      if (j == 1) begin
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h10) $display("FAIL bp_resume: got v=%b addr=%h expected 1/00000010", imem_req_valid, imem_req_addr);
        else n_pass++;
      end
    end
  endtask
  task automatic wait_first(input logic [31:0] pc, input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (instr_valid) begin
        seen = 1'b1;
        n_checks++;
        if (instr_pc !== pc || instr !== mem_word(pc)) $display("FAIL %s: got pc=%h i=%h expected pc=%h", name, instr_pc, instr, pc);
        else n_pass++;
      end
    end
    if (!seen) begin
      n_checks++;
      $display("FAIL %s: timeout waiting for instr_valid", name);
    end
  endtask
  task automatic test_redirect_drop;
    do_reset();
    lat = 3;
    imem_req_ready = 1'b1;
    instr_ready = 1'b1;
    tick();
    tick();
    imem_req_ready = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'h100;
    @(negedge clk);
    n_checks++;
    if (imem_req_valid !== 1'b0) $display("FAIL redir_req_low: got %b expected 0", imem_req_valid);
    else n_pass++;
    tick();
    redirect = 1'b0;
    imem_req_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) $display("FAIL redir_new_req: got v=%b addr=%h expected 1/00000100", imem_req_valid, imem_req_addr);
    else n_pass++;
    wait_first(32'h100, "redir_drop_first");
  endtask
  task automatic test_redirect_misaligned;
    do_reset();
    lat = 1;
    imem_req_ready = 1'b1;
    instr_ready = 1'b1;
    repeat (4) tick();
    redirect = 1'b1;
    redirect_pc = 32'h103;
    tick();
    redirect = 1'b0;
    @(negedge clk);
    n_checks++;
    if (imem_req_addr !== 32'h100) $display("FAIL misalign_addr: got %h expected 00000100", imem_req_addr);
    else n_pass++;
    wait_first(32'h100, "misalign_pc");
  endtask
  task automatic test_redirect_pop_rsp;
    do_reset();
    lat = 1;
    imem_req_ready = 1'b1;
    instr_ready = 1'b1;
    repeat (5) tick();
    redirect = 1'b1;
    redirect_pc = 32'h200;
    @(negedge clk);
    n_checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'hC) $display("FAIL rpop_deliver: got v=%b pc=%h expected 1/0000000c", instr_valid, instr_pc);
    else n_pass++;
    tick();
    redirect = 1'b0;
    @(negedge clk);
    n_checks++;
    if (instr_valid !== 1'b0) $display("FAIL rpop_empty: got %b expected 0", instr_valid);
    else n_pass++;
    wait_first(32'h200, "rpop_target");
  endtask
  task automatic test_reset_mid;
    do_reset();
    lat = 1;
    imem_req_ready = 1'b1;
    instr_ready = 1'b0;
    tick();
    tick();
    tick();
    imem_req_ready = 1'b0;
    tick();
    @(negedge clk);
    n_checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h0) $display("FAIL rmid_buffered: got v=%b pc=%h expected 1/00000000", instr_valid, instr_pc);
    else n_pass++;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0) $display("FAIL rmid_async: got v=%b i=%h pc=%h expected 0", instr_valid, instr, instr_pc);
    else n_pass++;
    tick();
    tick();
    rst = 1'b0;
    imem_req_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) $display("FAIL rmid_restart: got v=%b addr=%h expected 1/%h", imem_req_valid, imem_req_addr, RESET_PC);
    else n_pass++;
`ifdef FETCH_QUEUE_STATS_EN
    n_checks++;
    if (stall_cycles !== 32'h0 || dropped_rsps !== 32'h0) $display("FAIL rmid_stats: got %0d/%0d expected 0/0", stall_cycles, dropped_rsps);
    else n_pass++;
`endif
  endtask
  task automatic test_random;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      tick();
      imem_req_ready = $urandom_range(0, 3) != 0;
      instr_ready = $urandom_range(0, 2) != 0;
      lat = $urandom_range(1, 4);
      redirect = $urandom_range(0, 15) == 0;
      redirect_pc = $urandom;
      rst = $urandom_range(0, 799) == 0;
    end
    tick();
    rst = 1'b0;
    redirect = 1'b0;
    @(negedge clk);
  endtask
  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_drop();
    test_redirect_misaligned();
    test_redirect_pop_rsp();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch stage sitting directly upstream of the single-cycle core datapath. Issues sequential word requests to instruction memory over a valid/ready request channel, buffers in-order responses in a small FIFO, and presents each instruction with its PC to the core over a valid/ready handshake. Handles branch/jump redirects by flushing buffered instructions and dropping in-flight responses.

## Interface
- DEPTH, 4, FIFO entries and max outstanding memory requests (power of two, ≥2)
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- imem_req_valid  out  1  request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  word-aligned fetch address
- imem_rsp_valid  in  1  response valid, in order, no backpressure
- imem_rsp_instr  in  32  response instruction word
- instr_valid  out  1  FIFO head valid to core
- instr_ready  in  1  core consumes head
- instr  out  32  head instruction
- instr_pc  out  32  PC of head instruction
- redirect  in  1  taken branch/jump, single-cycle pulse
- redirect_pc  in  32  redirect target

## Operation
- Registers: fetch_pc (next request address), rsp_pc (PC of next accepted response), outstanding and drop counters ($clog2(DEPTH+1) bits), FIFO (instr+pc per entry, head/tail pointers, count).
- Request issue: imem_req_valid = !redirect && (count + outstanding < DEPTH). Handshake (valid&&ready): outstanding+1, fetch_pc += 4 (wraps mod 2^32).
- Response: each imem_rsp_valid decrements outstanding. If drop > 0: discard, drop-1. Else push {imem_rsp_instr, rsp_pc}, rsp_pc += 4. Issue rule guarantees no overflow.
- Output: instr_valid = (count != 0); instr/instr_pc = head entry when valid, else 0. Pop on instr_valid && instr_ready.
- Redirect: fetch_pc and rsp_pc ← {redirect_pc[31:2], 2'b00}; FIFO cleared; drop ← outstanding remaining after this cycle's response (a response arriving in the redirect cycle is discarded). Pop in redirect cycle is honored (consumer keeps that instruction), then queue empty.
- Simultaneous push and pop: count unchanged; push into empty FIFO not visible until next cycle.

## Timing
- Reset values: imem_req_addr = RESET_PC, instr_valid 0, instr 0, instr_pc 0, all counters 0, FIFO empty. imem_req_valid 1 in first cycle after rst deasserts.
- Minimum latency: request accept → response (memory, ≥1 cycle) → instr_valid next cycle.
- Throughput: 1 instruction/cycle sustained when memory ready every cycle and latency < DEPTH.
- Redirect: imem_req_valid low in redirect cycle; first new-target request the following cycle.
- Reset mid-operation: all state cleared asynchronously; instruction memory is reset by the same rst and returns no responses for pre-reset requests.

## Configuration
- FETCH_QUEUE_STATS_EN defined: adds outputs stall_cycles (32, counts cycles with instr_ready=1 and instr_valid=0) and dropped_rsps (32, counts discarded responses); both reset to 0, saturate at 32'hFFFF_FFFF.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Test plan
- Reset release, memory always ready, 1-cycle latency, instr_ready=1 → instr_pc 0x0,0x4,0x8,… one per cycle after 2-cycle fill; first imem_req_addr 0x0.
- instr_ready=0, DEPTH=4, 1-cycle latency → exactly 4 requests accepted, imem_req_valid then 0; raising instr_ready → drains PCs 0x0–0xC in order, fetch resumes at 0x10.
- 3-cycle latency, redirect to 0x100 with 2 outstanding → both responses dropped, next instr_valid shows instr_pc 0x100.
- redirect_pc 0x103 → imem_req_addr 0x100, instr_pc 0x100.
- Redirect coinciding with pop and response arrival → popped instruction delivered once, arriving response dropped, FIFO empty next cycle.
- rst pulsed mid-stream with 3 entries buffered → instr_valid 0 immediately; after release imem_req_addr = RESET_PC; with FETCH_QUEUE_STATS_EN, counters read 0.
